mem_arbiter_ctrl: RTL and testbench

- Parametrised multi-channel successor to the two-port memory controller.
- Arbitrates N_CH requesters (icache, LSB, future prefetcher/DMA) onto the single byte-serial RAM/IO bus.
- Assembles byte, half and word reads with sign/zero extension and serialises writes.
- Supports per-channel speculative-read abort on clear_all, and stalls IO writes while the UART buffer is full.

---
 rtl/mem_arbiter_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mem_arbiter_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// mem_arbiter_ctrl
//   Arbitrates N_CH requesters (channel 0 = icache) onto a single byte-serial
//   RAM/IO bus. Reads of byte/half/word are assembled little-endian and
//   sign/zero extended; writes are serialised one byte per cycle. Reads from
//   FLUSH_MASK channels are dropped on clear_all, and IO-region writes stall
//   while the UART transmit buffer is full.
//
//   Build option: define MEMARB_RR_EN for round-robin arbitration; without it
//   the lowest-index eligible channel always wins.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                global enable, all state frozen while low
//   mem_din               read byte, valid the cycle after its address
//   mem_dout, mem_a,
//   mem_wr                write byte, byte address, write strobe
//   io_buffer_full        UART tx buffer full
//   clear_all             misprediction flush
//   req_valid/wr/width/
//   addr/wdata            per-channel request bundles (packed by channel)
//   req_ack               one-hot grant pulse
//   resp_valid, resp_data one-hot completion pulse and extended read data
//   busy                  transfer in progress
// ---------------------------------------------------------------------------
module mem_arbiter_ctrl #(
    parameter int              N_CH       = 2,
    parameter int              ADDR_W     = 18,
    parameter logic [N_CH-1:0] FLUSH_MASK = 2'b01
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr,
    input  logic                 io_buffer_full,
    input  logic                 clear_all,
    input  logic [N_CH-1:0]      req_valid,
    input  logic [N_CH-1:0]      req_wr,
    input  logic [3*N_CH-1:0]    req_width,
    input  logic [32*N_CH-1:0]   req_addr,
    input  logic [32*N_CH-1:0]   req_wdata,
    output logic [N_CH-1:0]      req_ack,
    output logic [N_CH-1:0]      resp_valid,
    output logic [31:0]          resp_data,
    output logic                 busy
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

    state_t            state;
    logic [CH_W-1:0]   owner;
    logic [2:0]        op_wid;
    logic              op_io;
    logic [2:0]        cnt;
    logic [31:0]       rbuf;
    logic [23:0]       wbuf;
    logic [ADDR_W-1:0] addr_q;
`ifdef MEMARB_RR_EN
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W:0]     rr_idx;
`endif

    logic [N_CH-1:0]   eligible;
    logic              grant_found;
    logic [CH_W-1:0]   grant_idx;
    logic              sel_wr;
    logic              sel_io;
    logic [2:0]        sel_wid;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        nbytes;
    logic [31:0]       assembled;
    logic [31:0]       extended;
    logic              flush_hit;
    logic              unused_addr_hi;

    assign mem_a = {{(32-ADDR_W){1'b0}}, addr_q};

    // Eligible set: IO-region writes wait out a full UART buffer, flushable
    // channels sit out any cycle with clear_all asserted.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            eligible[i] = req_valid[i];
            if (req_wr[i] && io_buffer_full && (req_addr[32*i+16 +: 2] == 2'b11))
                eligible[i] = 1'b0;
            if (clear_all && FLUSH_MASK[i])
                eligible[i] = 1'b0;
        end
    end

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
`ifdef MEMARB_RR_EN
        rr_idx = '0;
        for (int unsigned off = 0; off < N_CH; off++) begin
            rr_idx = {1'b0, rr_ptr} + (CH_W+1)'(off);
            if (rr_idx >= (CH_W+1)'(N_CH))
                rr_idx = rr_idx - (CH_W+1)'(N_CH);
            if (!grant_found && eligible[rr_idx[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx[CH_W-1:0];
            end
        end
`else
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (!grant_found && eligible[i]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(i);
            end
        end
`endif
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_io    = 1'b0;
        sel_wid   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (CH_W'(i) == grant_idx) begin
                sel_wr    = req_wr[i];
                sel_io    = (req_addr[32*i+16 +: 2] == 2'b11);
                sel_wid   = req_width[3*i +: 3];
                sel_addr  = req_addr[32*i +: ADDR_W];
                sel_wdata = req_wdata[32*i +: 32];
            end
        end
    end

    // Address bits above ADDR_W never reach the bus.
    always_comb begin
        unused_addr_hi = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++)
            unused_addr_hi = unused_addr_hi ^ (^req_addr[32*i+ADDR_W +: 32-ADDR_W]);
    end

    always_comb begin
        case (op_wid[1:0])
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // At READ edge with count c, mem_din holds byte c-1 (address issued two
    // edges earlier), so the final byte is merged in the same edge as resp.
    always_comb begin
        assembled = rbuf;
        case (cnt)
            3'd1:    assembled[7:0]   = mem_din;
            3'd2:    assembled[15:8]  = mem_din;
            3'd3:    assembled[23:16] = mem_din;
            3'd4:    assembled[31:24] = mem_din;
            default: ;
        endcase
    end

    always_comb begin
        case (op_wid)
            3'b000:  extended = {{24{assembled[7]}}, assembled[7:0]};
            3'b100:  extended = {24'h0, assembled[7:0]};
            3'b001:  extended = {{16{assembled[15]}}, assembled[15:0]};
            3'b101:  extended = {16'h0, assembled[15:0]};
            default: extended = assembled;
        endcase
    end

    assign flush_hit = clear_all && FLUSH_MASK[owner];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            owner      <= '0;
            op_wid     <= '0;
            op_io      <= 1'b0;
            cnt        <= '0;
            rbuf       <= '0;
            wbuf       <= '0;
            addr_q     <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            req_ack    <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
`ifdef MEMARB_RR_EN
            rr_ptr     <= '0;
`endif
        end else if (rdy_in) begin
            req_ack    <= '0;
            resp_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        owner              <= grant_idx;
                        op_wid             <= sel_wid;
                        cnt                <= '0;
                        rbuf               <= '0;
                        addr_q             <= sel_addr;
                        busy               <= 1'b1;
                        req_ack[grant_idx] <= 1'b1;
`ifdef MEMARB_RR_EN
                        if (grant_idx == CH_W'(N_CH - 1))
                            rr_ptr <= '0;
                        else
                            rr_ptr <= grant_idx + 1'b1;
`endif
                        if (sel_wr) begin
                            state    <= S_WRITE;
                            op_io    <= sel_io;
                            mem_dout <= sel_wdata[7:0];
                            wbuf     <= sel_wdata[31:8];
                            mem_wr   <= 1'b1;
                        end else begin
                            state  <= S_READ;
                            op_io  <= 1'b0;
                            mem_wr <= 1'b0;
                        end
                    end
                end
                S_READ: begin
                    if (flush_hit) begin
                        state  <= S_IDLE;
                        busy   <= 1'b0;
                        mem_wr <= 1'b0;
                    end else if (cnt == nbytes) begin
                        resp_valid[owner] <= 1'b1;
                        resp_data         <= extended;
                        state             <= S_IDLE;
                        busy              <= 1'b0;
                    end else begin
                        cnt  <= cnt + 3'd1;
                        rbuf <= assembled;
                        if ((cnt + 3'd1) < nbytes)
                            addr_q <= addr_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    // cnt only advances when a byte is actually issued, so
                    // reaching n-1 means every byte has gone out.
                    if (cnt == nbytes - 3'd1) begin
                        mem_wr            <= 1'b0;
                        resp_valid[owner] <= 1'b1;
                        resp_data         <= '0;
                        state             <= S_IDLE;
                        busy              <= 1'b0;
                    end else if (op_io && io_buffer_full) begin
                        mem_wr <= 1'b0;
                    end else begin
                        cnt      <= cnt + 3'd1;
                        addr_q   <= addr_q + 1'b1;
                        mem_dout <= wbuf[7:0];
                        wbuf     <= {8'h00, wbuf[23:8]};
                        mem_wr   <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_ctrl
//   Directed bench for mem_arbiter_ctrl (N_CH=2, ADDR_W=18, FLUSH_MASK=01)
//   with a byte-wide RAM model. Define MEMARB_RR_EN for both files to
//   exercise the round-robin build.
// ---------------------------------------------------------------------------
module tb_mem_arbiter_ctrl;

    localparam int N = 2;
    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    logic             clk_in;
    logic             rst_in;
    logic             rdy_in;
    logic [7:0]       mem_din;
    logic [7:0]       mem_dout;
    logic [31:0]      mem_a;
    logic             mem_wr;
    logic             io_buffer_full;
    logic             clear_all;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_wr;
    logic [3*N-1:0]   req_width;
    logic [32*N-1:0]  req_addr;
    logic [32*N-1:0]  req_wdata;
    logic [N-1:0]     req_ack;
    logic [N-1:0]     resp_valid;
    logic [31:0]      resp_data;
    logic             busy;

    mem_arbiter_ctrl #(
        .N_CH       (2),
        .ADDR_W     (18),
        .FLUSH_MASK (2'b01)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .clear_all      (clear_all),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_width      (req_width),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ack        (req_ack),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .busy           (busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // RAM model: registered read one cycle after the address, plus a
    // preload port used while the DUT is idle.
    logic [7:0]  ram [0:262143];
    logic        pre_we;
    logic [17:0] pre_a;
    logic [7:0]  pre_d;
    int          io_cnt;
    logic [7:0]  io_byte;

    always @(posedge clk_in) begin
        if (pre_we)
            ram[pre_a] <= pre_d;
        else if (mem_wr)
            ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
        if (mem_wr && mem_a == 32'h0003_0000) begin
            io_cnt  <= io_cnt + 1;
            io_byte <= mem_dout;
        end
    end

    int n_cmp;
    int n_bad;

    logic [31:0] tr_a    [0:15];
    logic        tr_wr   [0:15];
    logic [7:0]  tr_dout [0:15];

    typedef struct {
        int          ch;
        logic        wr;
        logic [2:0]  wid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
        int          trace;     // 0 none, 1 read address trace, 2 store trace
    } vec_t;

    vec_t vecs [0:9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic record(input int k);
        if (k < 16) begin
            tr_a[k]    = mem_a;
            tr_wr[k]   = mem_wr;
            tr_dout[k] = mem_dout;
        end
    endtask

    task automatic poke(input logic [17:0] a, input logic [7:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk_in);
        pre_we = 1'b0;
    endtask

    task automatic start_req(input int ch, input logic wr, input logic [2:0] wid,
                             input logic [31:0] addr, input logic [31:0] wdata);
        req_wr[ch]             = wr;
        req_width[3*ch +: 3]   = wid;
        req_addr[32*ch +: 32]  = addr;
        req_wdata[32*ch +: 32] = wdata;
        req_valid[ch]          = 1'b1;
    endtask

    // Waits (bounded) for a grant; cyc = edges taken. Drops the request.
    task automatic wait_ack(input string name, input int ch, output int cyc);
        cyc = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            cyc++;
            if (req_ack != '0) break;
        end
        record(0);
        check({name, "_ack"}, 32'(req_ack), 32'(1) << ch);
        req_valid[ch] = 1'b0;
    endtask

    // Waits (bounded) for the completion pulse; lat = edges since call.
    task automatic wait_resp(input string name, input int ch, output int lat);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            lat++;
            record(lat);
            if (resp_valid != '0) break;
        end
        check({name, "_resp"}, 32'(resp_valid), 32'(1) << ch);
    endtask

    initial begin
        int cyc;
        int lat;
        int seen;
        int ng;
        int got [0:3];
        int exp_order [0:3];
        logic [31:0] wtmp;

        n_cmp = 0;
        n_bad = 0;
        io_cnt = 0;
        io_byte = '0;
        pre_we = 1'b0;
        pre_a = '0;
        pre_d = '0;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        clear_all = 1'b0;
        req_valid = '0;
        req_wr = '0;
        req_width = '0;
        req_addr = '0;
        req_wdata = '0;

        vecs[0] = '{0, 1'b0, W_W,  32'h0000_0100, 32'h0,          32'h1234_5678, 5, 1};
        vecs[1] = '{0, 1'b0, W_B,  32'h0000_0200, 32'h0,          32'hFFFF_FF80, 2, 0};
        vecs[2] = '{1, 1'b0, W_HU, 32'h0000_0200, 32'h0,          32'h0000_FF80, 3, 0};
        vecs[3] = '{1, 1'b0, W_H,  32'h0000_0200, 32'h0,          32'hFFFF_FF80, 3, 0};
        vecs[4] = '{0, 1'b0, W_BU, 32'h0000_0201, 32'h0,          32'h0000_00FF, 2, 0};
        vecs[5] = '{1, 1'b1, W_W,  32'h0000_0300, 32'hDEAD_BEEF,  32'h0,         4, 2};
        vecs[6] = '{0, 1'b0, W_W,  32'h0000_0300, 32'h0,          32'hDEAD_BEEF, 5, 0};
        vecs[7] = '{1, 1'b1, W_H,  32'h0000_0400, 32'h0000_A55A,  32'h0,         2, 0};
        vecs[8] = '{0, 1'b0, W_H,  32'h0000_0400, 32'h0,          32'hFFFF_A55A, 3, 0};
        vecs[9] = '{1, 1'b0, W_W,  32'hFFFF_FFFE, 32'h0,          32'h4433_2211, 5, 1};

        // Reset values
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_resp_data", resp_data, 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_req_ack", 32'(req_ack), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_in = 1'b0;

        poke(18'h00100, 8'h78);
        poke(18'h00101, 8'h56);
        poke(18'h00102, 8'h34);
        poke(18'h00103, 8'h12);
        poke(18'h00200, 8'h80);
        poke(18'h00201, 8'hFF);
        poke(18'h3FFFE, 8'h11);
        poke(18'h3FFFF, 8'h22);
        poke(18'h00000, 8'h33);
        poke(18'h00001, 8'h44);

        // Table-driven transfers
        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("v%0d", i);
            start_req(vecs[i].ch, vecs[i].wr, vecs[i].wid, vecs[i].addr, vecs[i].wdata);
            wait_ack(nm, vecs[i].ch, cyc);
            wait_resp(nm, vecs[i].ch, lat);
            check({nm, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({nm, "_data"}, resp_data, vecs[i].exp_data);
            if (vecs[i].trace == 1) begin
                for (int k = 0; k < vecs[i].exp_lat - 1; k++)
                    check($sformatf("%s_addr%0d", nm, k), tr_a[k],
                          (vecs[i].addr + 32'(k)) & 32'h0003_FFFF);
            end else if (vecs[i].trace == 2) begin
                for (int k = 0; k < vecs[i].exp_lat; k++) begin
                    wtmp = vecs[i].wdata >> (8 * k);
                    check($sformatf("%s_wr%0d", nm, k), 32'(tr_wr[k]), 32'h1);
                    check($sformatf("%s_dout%0d", nm, k), 32'(tr_dout[k]), 32'(wtmp[7:0]));
                    check($sformatf("%s_a%0d", nm, k), tr_a[k], vecs[i].addr + 32'(k));
                end
                check({nm, "_wr_end"}, 32'(tr_wr[vecs[i].exp_lat]), 32'h0);
            end
        end
        check("ram_store_word", {ram[18'h303], ram[18'h302], ram[18'h301], ram[18'h300]}, 32'hDEAD_BEEF);

        // IO write held off in IDLE while the UART buffer is full
        io_buffer_full = 1'b1;
        start_req(1, 1'b1, W_B, 32'h0003_0000, 32'h0000_0041);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("io_hold_ack%0d", k), 32'(req_ack), 32'h0);
            check($sformatf("io_hold_wr%0d", k), 32'(mem_wr), 32'h0);
        end
        io_buffer_full = 1'b0;
        wait_ack("io_sb", 1, cyc);
        check("io_sb_ack_cyc", 32'(cyc), 32'h1);
        wait_resp("io_sb", 1, lat);
        check("io_sb_lat", 32'(lat), 32'h1);
        check("io_sb_count", 32'(io_cnt), 32'h1);
        check("io_sb_byte", 32'(io_byte), 32'h41);

        // IO word write stalled mid-transfer for two edges
        start_req(1, 1'b1, W_W, 32'h0003_0010, 32'h4433_2211);
        wait_ack("io_sw", 1, cyc);
        io_buffer_full = 1'b1;
        step();
        check("io_sw_stall1", 32'(mem_wr), 32'h0);
        step();
        check("io_sw_stall2", 32'(mem_wr), 32'h0);
        io_buffer_full = 1'b0;
        wait_resp("io_sw", 1, lat);
        check("io_sw_lat", 32'(lat + 2), 32'h6);
        check("io_sw_ram", {ram[18'h30013], ram[18'h30012], ram[18'h30011], ram[18'h30010]},
              32'h4433_2211);

        // clear_all in IDLE keeps ch0 out of arbitration
        clear_all = 1'b1;
        start_req(0, 1'b0, W_W, 32'h0000_0100, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("flush_idle_ack%0d", k), 32'(req_ack), 32'h0);
        end
        clear_all = 1'b0;
        wait_ack("flush_idle", 0, cyc);
        wait_resp("flush_idle", 0, lat);
        check("flush_idle_data", resp_data, 32'h1234_5678);

        // ch0 word read aborted by clear_all in cycle 2; ch1 granted next edge
        start_req(0, 1'b0, W_W, 32'h0000_0100, 32'h0);
        wait_ack("abort_w", 0, cyc);
        step();
        step();
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        check("abort_w_busy", 32'(busy), 32'h0);
        check("abort_w_resp", 32'(resp_valid), 32'h0);
        start_req(1, 1'b0, W_W, 32'h0000_0100, 32'h0);
        wait_ack("regrant", 1, cyc);
        check("regrant_cyc", 32'(cyc), 32'h1);
        // ch1 is not flushable: the same pulse leaves its read intact
        step();
        step();
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        wait_resp("ch1_noabort", 1, lat);
        check("ch1_noabort_lat", 32'(lat + 3), 32'h5);
        check("ch1_noabort_data", resp_data, 32'h1234_5678);

        // clear_all on the final-byte edge of a masked byte read
        start_req(0, 1'b0, W_B, 32'h0000_0200, 32'h0);
        wait_ack("abort_b", 0, cyc);
        step();
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        seen = (resp_valid != '0) ? 1 : 0;
        check("abort_b_busy", 32'(busy), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            if (resp_valid != '0) seen++;
        end
        check("abort_b_noresp", 32'(seen), 32'h0);

        // Stores are never aborted
        start_req(1, 1'b1, W_W, 32'h0000_0500, 32'hCAFE_F00D);
        wait_ack("st_flush", 1, cyc);
        step();
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        wait_resp("st_flush", 1, lat);
        check("st_flush_lat", 32'(lat + 2), 32'h4);
        check("st_flush_ram", {ram[18'h503], ram[18'h502], ram[18'h501], ram[18'h500]},
              32'hCAFE_F00D);

        // rdy_in low freezes arbitration
        rdy_in = 1'b0;
        start_req(0, 1'b0, W_B, 32'h0000_0200, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rdy_ack%0d", k), 32'(req_ack), 32'h0);
            check($sformatf("rdy_busy%0d", k), 32'(busy), 32'h0);
        end
        rdy_in = 1'b1;
        wait_ack("rdy", 0, cyc);
        check("rdy_ack_cyc", 32'(cyc), 32'h1);
        wait_resp("rdy", 0, lat);
        check("rdy_lat", 32'(lat), 32'h2);
        check("rdy_data", resp_data, 32'hFFFF_FF80);

        // Reset in the middle of a word read
        start_req(0, 1'b0, W_W, 32'h0000_0100, 32'h0);
        wait_ack("midrst", 0, cyc);
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_mem_a", mem_a, 32'h0);
        check("midrst_resp_data", resp_data, 32'h0);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (resp_valid != '0) seen++;
        end
        check("midrst_noresp", 32'(seen), 32'h0);

        // Contention: both channels requesting continuously
`ifdef MEMARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        got = '{-1, -1, -1, -1};
        ng = 0;
        start_req(0, 1'b0, W_B, 32'h0000_0200, 32'h0);
        start_req(1, 1'b0, W_B, 32'h0000_0200, 32'h0);
        for (int c = 0; c < 60 && ng < 4; c++) begin
            step();
            if (req_ack != '0) begin
                got[ng] = req_ack[1] ? 1 : 0;
                ng++;
            end
        end
        req_valid = '0;
        check("arb_grants", 32'(ng), 32'h4);
        for (int k = 0; k < 4; k++)
            check($sformatf("arb_order%0d", k), 32'(got[k]), 32'(exp_order[k]));
        repeat (6) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
